cam_frame_position: RTL and testbench
=====================================

# cam_frame_position

Parametrised camera timing tracker for OV7670-class sensors, successor to the single-purpose row counter. Synchronises VSYNC/HREF/PCLK into the system clock domain and tracks both row and column with a frame/line state machine. Groups sensor bytes into pixels and emits pixel, line-end and frame-end strobes for downstream frame-buffer writers and line processors.

## Interface
- ROW_W, 9, width of PIXEL_ROW
- COL_W, 10, width of PIXEL_COL
- MAX_ROWS, 480, rows per frame; row index saturates at MAX_ROWS-1
- MAX_COLS, 640, pixels per line; column index saturates at MAX_COLS-1
- BYTES_PER_PIXEL, 2, PCLK rising edges per pixel (1..4)
- SYNC_STAGES, 2, synchroniser depth for VSYNC, HREF, PCLK (≥2)
- CLK  in  1  system clock; only clock in the block
- RST_N  in  1  asynchronous active-low reset
- START  in  1  level; enables frame capture
- VSYNC  in  1  camera vertical sync, high = vertical blanking
- HREF  in  1  camera line-valid, high = active bytes
- PCLK  in  1  camera pixel clock, sampled as data, never used as a clock
- PIXEL_ROW  out  ROW_W  current row index
- PIXEL_COL  out  COL_W  index of pixel qualified by PIXEL_VALID
- PIXEL_VALID  out  1  one-CLK strobe per completed pixel
- LINE_END  out  1  one-CLK strobe on HREF fall
- FRAME_END  out  1  one-CLK strobe on VSYNC rise inside a frame
- OVERFLOW  out  1  sticky; row or column saturated this frame
- DEBUG  out  1  toggles on every LINE_END

## Operation
- Reset: state IDLE; PIXEL_ROW=0, PIXEL_COL=0, all strobes 0, OVERFLOW=0, DEBUG=0, synchronisers and byte counter 0.
- Edges detected on synchronised signals by comparison with one extra registered copy.
- IDLE: START=1 → WAIT_VSYNC.
- WAIT_VSYNC: VSYNC falling edge → FRAME; PIXEL_ROW=0, PIXEL_COL=0, byte counter=0, OVERFLOW=0. START=0 → IDLE.
- FRAME: HREF rising edge → LINE; PIXEL_COL=0, byte counter=0. VSYNC rising edge → FRAME_END=1; next state WAIT_VSYNC if START=1, else IDLE.
- LINE: each PCLK rising edge with HREF high increments byte counter; at count BYTES_PER_PIXEL-1, PIXEL_VALID=1 with PIXEL_COL = pixel index, counter wraps to 0, PIXEL_COL increments next cycle.
- LINE: HREF falling edge → LINE_END=1, DEBUG toggles, PIXEL_ROW+1, partial pixel bytes discarded → FRAME.
- Same-cycle PCLK completion and HREF fall: PIXEL_VALID and LINE_END both asserted; pixel counted on the current row.
- VSYNC rising in LINE: line aborted, FRAME_END=1, no LINE_END, row not incremented.
- Column already MAX_COLS-1 when a pixel completes: PIXEL_VALID still pulses, PIXEL_COL holds, OVERFLOW=1. Row at MAX_ROWS-1 on LINE_END: row holds, OVERFLOW=1.
- START falling mid-frame: current frame completes normally, then IDLE.

## Timing
- Pin edge to strobe/state change: SYNC_STAGES+1 CLK cycles (3 by default).
- Strobes are single-cycle, registered, never back-to-back for the same event.
- PCLK high and low phases each ≥ 2 CLK periods (f_CLK ≥ 4·f_PCLK); otherwise edges are missed, no error reported.
- PIXEL_ROW/PIXEL_COL registered; stable during PIXEL_VALID.
- RST_N asserted mid-frame: immediate return to reset values; capture resumes only after next VSYNC fall with START=1.

## Configuration
- CAM_FRAME_STATS_EN defined: adds outputs LAST_ROWS [ROW_W] (rows completed, latched on FRAME_END) and LAST_COLS [COL_W] (pixels in last line, latched on LINE_END); both reset to 0; saturated values when OVERFLOW.
- Undefined: ports and registers absent; remaining behaviour identical.

## Test plan
- Reset, START=1, one 4-line × 8-pixel frame, BYTES_PER_PIXEL=2 → 32 PIXEL_VALID, COL 0..7 per line, ROW 0..3, 4 LINE_END, 1 FRAME_END, DEBUG ends 0.
- START=0 throughout a frame → no strobes, ROW/COL stay 0, state IDLE.
- MAX_COLS=4, line of 6 pixels → 6 PIXEL_VALID, COL sticks at 3, OVERFLOW=1; cleared at next VSYNC fall.
- HREF falls after 3 bytes (BYTES_PER_PIXEL=2) → 1 PIXEL_VALID, LINE_END, ROW +1; VSYNC rise mid-line → FRAME_END, no LINE_END.
- RST_N low for 1 cycle during line 2 → all outputs 0; next frame starts at ROW 0.
- With CAM_FRAME_STATS_EN, 3-line × 5-pixel frame → LAST_COLS=5 after each LINE_END, LAST_ROWS=3 after FRAME_END.

Source files
------------

// File: rtl/cam_frame_position.sv
// cam_frame_position: OV7670 timing tracker; synchronises VSYNC/HREF/PCLK, tracks row/column, emits pixel/line/frame strobes.
// Define CAM_FRAME_STATS_EN to add the LAST_ROWS/LAST_COLS statistics outputs.
module cam_frame_position #(
   parameter int ROW_W           = 9,
   parameter int COL_W           = 10,
   parameter int MAX_ROWS        = 480,
   parameter int MAX_COLS        = 640,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int SYNC_STAGES     = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             VSYNC,
   input  logic             HREF,
   input  logic             PCLK,
   output logic [ROW_W-1:0] PIXEL_ROW,
   output logic [COL_W-1:0] PIXEL_COL,
   output logic             PIXEL_VALID,
   output logic             LINE_END,
   output logic             FRAME_END,
   output logic             OVERFLOW,
   output logic             DEBUG
`ifdef CAM_FRAME_STATS_EN
   ,
   output logic [ROW_W-1:0] LAST_ROWS,
   output logic [COL_W-1:0] LAST_COLS
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT_VSYNC, FRAME, LINE} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] v_sr, h_sr, p_sr;
   logic v_d, h_d, p_d;
   logic [1:0] byte_cnt;
   logic v_rise, v_fall, h_rise, h_fall, p_rise;
   logic frame_go, line_go, byte_inc, pix_done, le, fe;

   assign v_rise = v_sr[SYNC_STAGES-1] & ~v_d;
   assign v_fall = ~v_sr[SYNC_STAGES-1] & v_d;
   assign h_rise = h_sr[SYNC_STAGES-1] & ~h_d;
   assign h_fall = ~h_sr[SYNC_STAGES-1] & h_d;
   assign p_rise = p_sr[SYNC_STAGES-1] & ~p_d;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else state <= state_nx;

   // A PCLK edge coinciding with the HREF fall still belongs to the line.
   always_comb begin
      state_nx = state;
      frame_go = 1'b0;
      line_go  = 1'b0;
      byte_inc = 1'b0;
      pix_done = 1'b0;
      le       = 1'b0;
      fe       = 1'b0;
      case (state)
         IDLE: state_nx = START ? WAIT_VSYNC : IDLE;
         WAIT_VSYNC: begin
            frame_go = START & v_fall;
            state_nx = !START ? IDLE : v_fall ? FRAME : WAIT_VSYNC;
         end
         FRAME: begin
            fe       = v_rise;
            line_go  = ~v_rise & h_rise;
            state_nx = v_rise ? (START ? WAIT_VSYNC : IDLE) : h_rise ? LINE : FRAME;
         end
         default: begin
            fe       = v_rise;
            byte_inc = ~v_rise & p_rise;
            pix_done = byte_inc & (byte_cnt == 2'(BYTES_PER_PIXEL-1));
            le       = ~v_rise & h_fall;
            state_nx = v_rise ? (START ? WAIT_VSYNC : IDLE) : h_fall ? FRAME : LINE;
         end
      endcase
   end

   // Row/column advance the cycle after their strobe so they stay stable while it is high.
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         v_sr        <= '0;
         h_sr        <= '0;
         p_sr        <= '0;
         v_d         <= 1'b0;
         h_d         <= 1'b0;
         p_d         <= 1'b0;
         byte_cnt    <= '0;
         PIXEL_ROW   <= '0;
         PIXEL_COL   <= '0;
         PIXEL_VALID <= 1'b0;
         LINE_END    <= 1'b0;
         FRAME_END   <= 1'b0;
         OVERFLOW    <= 1'b0;
         DEBUG       <= 1'b0;
      end else begin
         v_sr        <= {v_sr[SYNC_STAGES-2:0], VSYNC};
         h_sr        <= {h_sr[SYNC_STAGES-2:0], HREF};
         p_sr        <= {p_sr[SYNC_STAGES-2:0], PCLK};
         v_d         <= v_sr[SYNC_STAGES-1];
         h_d         <= h_sr[SYNC_STAGES-1];
         p_d         <= p_sr[SYNC_STAGES-1];
         PIXEL_VALID <= pix_done;
         LINE_END    <= le;
         FRAME_END   <= fe;
         if (le) DEBUG <= ~DEBUG;
         byte_cnt <= (frame_go || line_go || pix_done || le) ? '0 : byte_inc ? byte_cnt + 2'd1 : byte_cnt;
         if (frame_go) begin
            PIXEL_ROW <= '0;
            PIXEL_COL <= '0;
            OVERFLOW  <= 1'b0;
         end else begin
            if (line_go) PIXEL_COL <= '0;
            else if (PIXEL_VALID && PIXEL_COL != COL_W'(MAX_COLS-1)) PIXEL_COL <= PIXEL_COL + 1'b1;
            if (LINE_END && PIXEL_ROW != ROW_W'(MAX_ROWS-1)) PIXEL_ROW <= PIXEL_ROW + 1'b1;
            if ((PIXEL_VALID && PIXEL_COL == COL_W'(MAX_COLS-1)) ||
                (LINE_END && PIXEL_ROW == ROW_W'(MAX_ROWS-1))) OVERFLOW <= 1'b1;
         end
      end

`ifdef CAM_FRAME_STATS_EN
   logic [COL_W-1:0] ln_cnt, ln_nx;
   logic [ROW_W-1:0] fr_cnt;

   assign ln_nx = (pix_done && ln_cnt != COL_W'(MAX_COLS)) ? ln_cnt + 1'b1 : ln_cnt;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         ln_cnt    <= '0;
         fr_cnt    <= '0;
         LAST_ROWS <= '0;
         LAST_COLS <= '0;
      end else begin
         ln_cnt <= line_go ? '0 : ln_nx;
         fr_cnt <= frame_go ? '0 : (le && fr_cnt != ROW_W'(MAX_ROWS)) ? fr_cnt + 1'b1 : fr_cnt;
         if (le) LAST_COLS <= ln_nx;
         if (fe) LAST_ROWS <= fr_cnt;
      end
`endif
endmodule

// File: tb/tb_cam_frame_position.sv
// tb_cam_frame_position: randomized frames against an event-list reference model of the camera tracker.
module tb_cam_frame_position;
   localparam int BPP = 2;
   localparam int MC  = 8;
   localparam int MR  = 6;

   logic       CLK, RST_N, START, VSYNC, HREF, PCLK;
   logic [8:0] PIXEL_ROW;
   logic [9:0] PIXEL_COL;
   logic       PIXEL_VALID, LINE_END, FRAME_END, OVERFLOW, DEBUG;
`ifdef CAM_FRAME_STATS_EN
   logic [8:0] LAST_ROWS;
   logic [9:0] LAST_COLS;
`endif

   cam_frame_position #(.MAX_ROWS(MR), .MAX_COLS(MC), .BYTES_PER_PIXEL(BPP)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK),
      .PIXEL_ROW(PIXEL_ROW), .PIXEL_COL(PIXEL_COL), .PIXEL_VALID(PIXEL_VALID),
      .LINE_END(LINE_END), .FRAME_END(FRAME_END), .OVERFLOW(OVERFLOW), .DEBUG(DEBUG)
`ifdef CAM_FRAME_STATS_EN
      , .LAST_ROWS(LAST_ROWS), .LAST_COLS(LAST_COLS)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {int k; int row; int col; int n; bit dbg;} ev_t;
   ev_t q[$];
   int total = 0, bad = 0;
   int obs_pix = 0, obs_le = 0, obs_fe = 0;
   int m_row, m_col, m_bytes, m_lpix, m_lines;
   bit m_ovf, m_dbg, m_in_frame, m_in_line;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   function automatic int min2(int a, int b);
      return a < b ? a : b;
   endfunction

   task automatic m_reset();
      q.delete();
      m_row = 0; m_col = 0; m_bytes = 0; m_lpix = 0; m_lines = 0;
      m_ovf = 0; m_dbg = 0; m_in_frame = 0; m_in_line = 0;
   endtask

   task automatic m_vfall();
      m_in_frame = START;
      m_in_line  = 0;
      if (START) begin
         m_row = 0; m_col = 0; m_ovf = 0; m_lines = 0;
      end
   endtask

   task automatic m_vrise();
      if (m_in_frame) q.push_back('{2, m_row, m_col, min2(m_lines, MR), m_dbg});
      m_in_frame = 0;
      m_in_line  = 0;
   endtask

   task automatic m_hrise();
      if (m_in_frame && !m_in_line) begin
         m_in_line = 1; m_col = 0; m_bytes = 0; m_lpix = 0;
      end
   endtask

   task automatic m_pclk();
      if (m_in_line) begin
         m_bytes++;
         if (m_bytes == BPP) begin
            q.push_back('{0, m_row, m_col, 0, m_dbg});
            m_lpix++;
            m_bytes = 0;
            if (m_col == MC-1) m_ovf = 1; else m_col++;
         end
      end
   endtask

   task automatic m_hfall();
      if (m_in_line) begin
         m_dbg = ~m_dbg;
         q.push_back('{1, m_row, m_col, min2(m_lpix, MC), m_dbg});
         m_lines++;
         if (m_row == MR-1) m_ovf = 1; else m_row++;
         m_in_line = 0;
      end
   endtask

   task automatic take(int k);
      ev_t e;
      chk("strobe_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("strobe_kind", k, e.k);
         if (k == 0) begin
            chk("pix_row", PIXEL_ROW, e.row);
            chk("pix_col", PIXEL_COL, e.col);
         end
         if (k == 1) begin
            chk("le_row", PIXEL_ROW, e.row);
            chk("le_dbg", DEBUG, e.dbg);
`ifdef CAM_FRAME_STATS_EN
            chk("last_cols", LAST_COLS, e.n);
`endif
         end
`ifdef CAM_FRAME_STATS_EN
         if (k == 2) chk("last_rows", LAST_ROWS, e.n);
`endif
      end
   endtask

   always @(negedge CLK)
      if (RST_N) begin
         if (PIXEL_VALID) begin obs_pix++; take(0); end
         if (LINE_END) begin obs_le++; take(1); end
         if (FRAME_END) begin obs_fe++; take(2); end
      end

   task automatic byte_edge();
      PCLK = 1; m_pclk(); cyc(3);
      PCLK = 0; cyc(3);
   endtask

   task automatic line(int nb, bit mg);
      HREF = 1; m_hrise(); cyc(4);
      for (int i = 0; i < nb; i++) begin
         PCLK = 1; m_pclk();
         if (mg && i == nb-1) begin HREF = 0; m_hfall(); end
         cyc(3); PCLK = 0; cyc(3);
      end
      if (!(mg && nb > 0)) begin HREF = 0; m_hfall(); end
      cyc(6);
   endtask

   task automatic line_abort(int nb);
      HREF = 1; m_hrise(); cyc(4);
      for (int i = 0; i < nb; i++) byte_edge();
      VSYNC = 1; m_vrise(); cyc(6);
      HREF = 0; m_hfall(); cyc(6);
   endtask

   task automatic frame(int nl, int nb, bit ab, bit drop);
      int b;
      VSYNC = 0; m_vfall(); cyc(8);
      chk("ovf_at_start", OVERFLOW, m_ovf);
      for (int l = 0; l < nl; l++) begin
         b = nb < 0 ? int'($urandom_range(0, 21)) : nb;
         if (ab && l == nl-1) line_abort(b);
         else line(b, nb < 0 ? 1'($urandom_range(0, 1)) : 1'b0);
         if (drop && l == 0) START = 0;
      end
      if (!ab) begin VSYNC = 1; m_vrise(); end
      cyc(8);
      for (int i = 0; i < 40 && q.size() > 0; i++) cyc(1);
      chk("drain", q.size(), 0);
      chk("frame_row", PIXEL_ROW, m_row);
      chk("frame_col", PIXEL_COL, m_col);
      chk("frame_ovf", OVERFLOW, m_ovf);
      chk("frame_dbg", DEBUG, m_dbg);
   endtask

   initial begin
      int p0, l0, f0;
      RST_N = 0; START = 0; VSYNC = 1; HREF = 0; PCLK = 0;
      m_reset();
      cyc(3);
      chk("rst_row", PIXEL_ROW, 0);
      chk("rst_col", PIXEL_COL, 0);
      chk("rst_valid", PIXEL_VALID, 0);
      chk("rst_le", LINE_END, 0);
      chk("rst_fe", FRAME_END, 0);
      chk("rst_ovf", OVERFLOW, 0);
      chk("rst_dbg", DEBUG, 0);
`ifdef CAM_FRAME_STATS_EN
      chk("rst_last_rows", LAST_ROWS, 0);
      chk("rst_last_cols", LAST_COLS, 0);
`endif
      RST_N = 1; cyc(6);

      p0 = obs_pix; l0 = obs_le; f0 = obs_fe;
      frame(3, 16, 0, 0);
      chk("idle_pix_cnt", obs_pix - p0, 0);
      chk("idle_le_cnt", obs_le - l0, 0);
      chk("idle_fe_cnt", obs_fe - f0, 0);

      START = 1; cyc(4);
      p0 = obs_pix; l0 = obs_le; f0 = obs_fe;
      frame(4, 16, 0, 0);
      chk("pix_cnt", obs_pix - p0, 32);
      chk("le_cnt", obs_le - l0, 4);
      chk("fe_cnt", obs_fe - f0, 1);
      chk("dbg_end", DEBUG, 0);

      frame(2, 20, 0, 0);
      chk("col_sat_ovf", OVERFLOW, 1);
      chk("col_sat_col", PIXEL_COL, MC-1);
      frame(3, 10, 0, 0);
      frame(2, 3, 1, 0);

      VSYNC = 0; m_vfall(); cyc(8);
      line(16, 0);
      HREF = 1; m_hrise(); cyc(4);
      repeat (3) byte_edge();
      RST_N = 0; m_reset(); #2;
      chk("mid_rst_row", PIXEL_ROW, 0);
      chk("mid_rst_col", PIXEL_COL, 0);
      chk("mid_rst_ovf", OVERFLOW, 0);
      chk("mid_rst_dbg", DEBUG, 0);
      chk("mid_rst_valid", PIXEL_VALID, 0);
      @(posedge CLK); #1;
      RST_N = 1;
      repeat (2) byte_edge();
      HREF = 0; m_hfall(); cyc(6);
      VSYNC = 1; m_vrise(); cyc(10);
      frame(2, 8, 0, 0);

      repeat (12) begin
         START = ($urandom_range(0, 5) != 0);
         cyc(4);
         frame(int'($urandom_range(1, 8)), -1, $urandom_range(0, 4) == 0, START && $urandom_range(0, 5) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
